// File: rtl/alut_age_checker_rsp_if.sv
// Age-check request/response handshake plus the ALUT memory port dedicated to the age checker.
// The master modport is used by the address checker and memory side; the slave modport is used by the responder.
interface alut_age_checker_rsp_if #(
    parameter int ADDR_W = 8,
    parameter int TIME_W = 32
);
    logic              check_age;
    logic [TIME_W-1:0] last_accessed;
    logic              age_confirmed;
    logic              age_ok;
    logic              add_check_active;
    logic [82:0]       mem_read_data_age;
    logic [ADDR_W-1:0] mem_addr_age;
    logic              mem_write_age;
    logic [82:0]       mem_write_data_age;

    modport master (
        output check_age, last_accessed, add_check_active, mem_read_data_age,
        input  age_confirmed, age_ok, mem_addr_age, mem_write_age, mem_write_data_age
    );

    modport slave (
        input  check_age, last_accessed, add_check_active, mem_read_data_age,
        output age_confirmed, age_ok, mem_addr_age, mem_write_age, mem_write_data_age
    );
endinterface

// File: rtl/alut_age_checker_rsp.sv
// ALUT age-check responder and background aging sweep; ALUT_AGE_WRAP_EN selects modular ages for future timestamps.
// Latency: check_age answered exactly one cycle later; the sweep takes 4-5 cycles per location, plus stall cycles.
// Backpressure: the sweep yields the memory to add_check_active, and its comparator yields to check_age.
module alut_age_checker_rsp #(
    parameter int ADDR_W = 8,
    parameter int TIME_W = 32
) (
    input  logic                   pclk,
    input  logic                   n_p_reset,
    input  logic [1:0]             command,
    input  logic [TIME_W-1:0]      max_age,
    input  logic [TIME_W-1:0]      curr_time,
    alut_age_checker_rsp_if.slave  age_if,
    output logic                   age_sweep_active,
    output logic                   sweep_done,
    output logic [47:0]            lst_inv_addr_cmd,
    output logic [1:0]             lst_inv_port_cmd,
    output logic [ADDR_W:0]        inval_count
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EVAL, S_WR, S_NEXT} state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR  = '1;
    localparam logic [1:0]        CMD_SWEEP = 2'b10;

    // When wrapping is disabled, a timestamp in the future is treated as corrupt and is reported out of date.
    function automatic logic out_of_date(input logic [TIME_W-1:0] entry_time,
                                         input logic [TIME_W-1:0] now,
                                         input logic [TIME_W-1:0] limit);
        logic [TIME_W-1:0] age;
        age = now - entry_time;
`ifdef ALUT_AGE_WRAP_EN
        out_of_date = age > limit;
`else
        out_of_date = (entry_time > now) || (age > limit);
`endif
    endfunction

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] ptr;
    logic [82:0]       rd_data;
    logic              stale;
    logic              wr_fire;

    assign stale   = rd_data[82] & out_of_date(rd_data[81:50], curr_time, max_age);
    assign wr_fire = (state == S_WR) && !age_if.add_check_active;

    always_ff @(posedge pclk) begin
        if (!n_p_reset) begin
            age_if.age_confirmed <= 1'b0;
            age_if.age_ok        <= 1'b0;
        end else begin
            age_if.age_confirmed <= age_if.check_age;
            if (age_if.check_age)
                age_if.age_ok <= !out_of_date(age_if.last_accessed, curr_time, max_age);
        end
    end

    always_ff @(posedge pclk) begin
        if (!n_p_reset) state <= S_IDLE;
        else            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE: if (command == CMD_SWEEP) nxt_state = S_RD;
            S_RD:   if (!age_if.add_check_active) nxt_state = S_WAIT;
            S_WAIT: nxt_state = age_if.add_check_active ? S_RD : S_EVAL;
            // The comparator is shared with the request path, so EVAL holds while a request is being answered.
            S_EVAL: if (!age_if.check_age) nxt_state = stale ? S_WR : S_NEXT;
            S_WR:   nxt_state = age_if.add_check_active ? S_RD : S_NEXT;
            S_NEXT: nxt_state = (ptr == LAST_PTR) ? S_IDLE : S_RD;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!n_p_reset) begin
            ptr              <= '0;
            rd_data          <= '0;
            lst_inv_addr_cmd <= '0;
            lst_inv_port_cmd <= '0;
            inval_count      <= '0;
            sweep_done       <= 1'b0;
        end else begin
            sweep_done <= (state == S_NEXT) && (ptr == LAST_PTR);
            if (state == S_IDLE && command == CMD_SWEEP) begin
                ptr         <= '0;
                inval_count <= '0;
            end
            if (state == S_NEXT && ptr != LAST_PTR)
                ptr <= ptr + 1'b1;
            if (state == S_WAIT && !age_if.add_check_active)
                rd_data <= age_if.mem_read_data_age;
            if (wr_fire) begin
                lst_inv_addr_cmd <= rd_data[47:0];
                lst_inv_port_cmd <= rd_data[49:48];
                inval_count      <= inval_count + 1'b1;
            end
        end
    end

    always_comb begin
        age_sweep_active          = (state != S_IDLE);
        age_if.mem_addr_age       = ptr;
        age_if.mem_write_age      = wr_fire && n_p_reset;
        age_if.mem_write_data_age = age_if.mem_write_age ? {1'b0, rd_data[81:0]} : '0;
    end
endmodule

// File: tb/tb_alut_age_checker_rsp.sv
// Bench for alut_age_checker_rsp: request vectors, a random request model, and sweeps over a modelled ALUT RAM
// that include contention and reset scenarios.
module tb_alut_age_checker_rsp;
    localparam int ADDR_W = 8;
    localparam int TIME_W = 32;
    localparam int DEPTH  = 256;
`ifdef ALUT_AGE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        n_p_reset;
    logic [1:0]  command;
    logic [31:0] max_age, curr_time;
    logic        age_sweep_active, sweep_done;
    logic [47:0] lst_inv_addr_cmd;
    logic [1:0]  lst_inv_port_cmd;
    logic [8:0]  inval_count;

    always #5 pclk = ~pclk;

    alut_age_checker_rsp_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) age_if ();

    alut_age_checker_rsp #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
        .pclk             (pclk),
        .n_p_reset        (n_p_reset),
        .command          (command),
        .max_age          (max_age),
        .curr_time        (curr_time),
        .age_if           (age_if),
        .age_sweep_active (age_sweep_active),
        .sweep_done       (sweep_done),
        .lst_inv_addr_cmd (lst_inv_addr_cmd),
        .lst_inv_port_cmd (lst_inv_port_cmd),
        .inval_count      (inval_count)
    );

    // RAM model: while the address checker owns the memory, reads follow chk_addr instead.
    typedef struct { logic [7:0] a; logic [82:0] d; } wr_t;
    logic [82:0] mem [DEPTH];
    logic [82:0] img [DEPTH];
    logic        load;
    logic [7:0]  chk_addr;
    wr_t         wr_log [$];
    wire  [7:0]  ram_addr = age_if.add_check_active ? chk_addr : age_if.mem_addr_age;

    always @(posedge pclk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (age_if.mem_write_age) begin
            mem[age_if.mem_addr_age] <= age_if.mem_write_data_age;
            wr_log.push_back('{age_if.mem_addr_age, age_if.mem_write_data_age});
        end
        age_if.mem_read_data_age <= mem[ram_addr];
    end

    int n_cmp = 0, n_bad = 0, done_cnt = 0;
    logic exp_conf = 1'b0, exp_ok = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit tb_in_date(input longint unsigned ct, input longint unsigned et,
                                      input longint unsigned ma);
        longint unsigned age;
        if (WRAP) age = (ct + 64'h1_0000_0000 - et) % 64'h1_0000_0000;
        else if (et > ct) return 1'b0;
        else age = ct - et;
        return age <= ma;
    endfunction

    function automatic logic [82:0] mk(input bit v, input logic [31:0] t, input logic [1:0] p,
                                       input logic [47:0] a);
        return {v, t, p, a};
    endfunction

    // One clock: the request model takes its decision at the edge, and outputs are compared at the falling edge.
    task automatic cycle();
        @(posedge pclk);
        if (!n_p_reset) begin
            exp_conf = 1'b0;
            exp_ok   = 1'b0;
        end else begin
            exp_conf = age_if.check_age;
            if (age_if.check_age) exp_ok = tb_in_date(curr_time, age_if.last_accessed, max_age);
        end
        @(negedge pclk);
        chk("rsp_confirmed", age_if.age_confirmed, exp_conf);
        chk("rsp_ok", age_if.age_ok, exp_ok);
        if (age_if.add_check_active) chk("write_while_busy", age_if.mem_write_age, 1'b0);
        if (sweep_done) done_cnt++;
    endtask

    task automatic load_img();
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_addr(input logic [7:0] a);
        int b = 0;
        while (age_if.mem_addr_age != a && b < 3000) begin cycle(); b++; end
        chk("reach_ptr", age_if.mem_addr_age, a);
    endtask

    // Start a sweep (or continue one already running when fresh=0) and check it against the snapshot rule.
    task automatic run_sweep(input bit rnd, input bit fresh, input string tag);
        logic [82:0] snap [DEPTH];
        int exp_a [$];
        int base, dbase, b, nbad;
        for (int i = 0; i < DEPTH; i++) begin
            snap[i] = mem[i];
            if (snap[i][82] && !tb_in_date(curr_time, snap[i][81:50], max_age)) exp_a.push_back(i);
        end
        base = wr_log.size();
        dbase = done_cnt;
        if (fresh) begin
            command = 2'b10;
            cycle();
            command = 2'b00;
            chk({tag, "_active"}, age_sweep_active, 1'b1);
            chk({tag, "_start_ptr"}, age_if.mem_addr_age, 8'h00);
        end
        b = 0;
        while (age_sweep_active && b < 9000) begin
            if (rnd) begin
                if ($urandom_range(0, 7) == 0) age_if.add_check_active = ~age_if.add_check_active;
                chk_addr = 8'($urandom);
                age_if.check_age = ($urandom_range(0, 4) == 0);
                age_if.last_accessed = curr_time - $urandom_range(0, 300);
                command = ($urandom_range(0, 40) == 0) ? 2'b10 : 2'($urandom_range(0, 1) * 3);
            end
            cycle();
            b++;
        end
        age_if.add_check_active = 1'b0;
        age_if.check_age = 1'b0;
        command = 2'b00;
        chk({tag, "_ended"}, age_sweep_active, 1'b0);
        chk({tag, "_nwrites"}, wr_log.size() - base, exp_a.size());
        for (int k = 0; k < exp_a.size() && base + k < wr_log.size(); k++) begin
            chk({tag, "_wr_addr"}, wr_log[base + k].a, exp_a[k]);
            chk({tag, "_wr_data"}, wr_log[base + k].d, {1'b0, snap[exp_a[k]][81:0]});
        end
        chk({tag, "_inval_count"}, inval_count, exp_a.size());
        if (exp_a.size() > 0) begin
            chk({tag, "_lst_addr"}, lst_inv_addr_cmd, snap[exp_a[exp_a.size() - 1]][47:0]);
            chk({tag, "_lst_port"}, lst_inv_port_cmd, snap[exp_a[exp_a.size() - 1]][49:48]);
        end
        chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [82:0] e;
            e = snap[i];
            if (snap[i][82] && !tb_in_date(curr_time, snap[i][81:50], max_age)) e[82] = 1'b0;
            if (mem[i] !== e) nbad++;
        end
        chk({tag, "_mem_image"}, nbad, 0);
    endtask

    typedef struct { logic [31:0] ma, ct, la; logic ok; } vec_t;
    vec_t vt [8];

    initial begin
        int base;
        vt[0] = '{32'd100, 32'd1000, 32'd950, 1'b1};
        vt[1] = '{32'd100, 32'd1000, 32'd900, 1'b1};
        vt[2] = '{32'd100, 32'd1000, 32'd899, 1'b0};
        vt[3] = '{32'd10, 32'd5, 32'hFFFF_FFFE, WRAP};
        vt[4] = '{32'd0, 32'd77, 32'd77, 1'b1};
        vt[5] = '{32'd0, 32'd77, 32'd76, 1'b0};
        vt[6] = '{32'd50, 32'd10, 32'd20, 1'b0};
        vt[7] = '{32'hFFFF_FFFF, 32'd0, 32'd1, WRAP};

        n_p_reset = 1'b0; command = 2'b00; max_age = '0; curr_time = '0; load = 1'b0; chk_addr = '0;
        age_if.check_age = 1'b0; age_if.last_accessed = '0; age_if.add_check_active = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_confirmed", age_if.age_confirmed, 1'b0);
        chk("rst_ok", age_if.age_ok, 1'b0);
        chk("rst_addr", age_if.mem_addr_age, 8'h00);
        chk("rst_wr", age_if.mem_write_age, 1'b0);
        chk("rst_wdata", age_if.mem_write_data_age, 83'h0);
        chk("rst_active", age_sweep_active, 1'b0);
        chk("rst_done", sweep_done, 1'b0);
        chk("rst_lst_addr", lst_inv_addr_cmd, 48'h0);
        chk("rst_lst_port", lst_inv_port_cmd, 2'h0);
        chk("rst_inval", inval_count, 9'h0);
        n_p_reset = 1'b1;
        cycle();

        for (int v = 0; v < 8; v++) begin
            max_age = vt[v].ma; curr_time = vt[v].ct; age_if.last_accessed = vt[v].la;
            age_if.check_age = 1'b1;
            cycle();
            age_if.check_age = 1'b0;
            chk("vec_strobe", age_if.age_confirmed, 1'b1);
            chk("vec_ok", age_if.age_ok, vt[v].ok);
            cycle();
            chk("vec_strobe_end", age_if.age_confirmed, 1'b0);
            chk("vec_ok_held", age_if.age_ok, vt[v].ok);
        end

        // Back-to-back requests: the second arrives while the first is being confirmed.
        max_age = 32'd100; curr_time = 32'd1000;
        age_if.last_accessed = 32'd950; age_if.check_age = 1'b1;
        cycle();
        age_if.last_accessed = 32'd800;
        chk("b2b_first_ok", age_if.age_ok, 1'b1);
        cycle();
        age_if.check_age = 1'b0;
        chk("b2b_second_strobe", age_if.age_confirmed, 1'b1);
        chk("b2b_second_ok", age_if.age_ok, 1'b0);
        cycle();

        for (int n = 0; n < 300; n++) begin
            curr_time = $urandom;
            max_age = $urandom_range(0, 150);
            age_if.check_age = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0: age_if.last_accessed = curr_time - $urandom_range(0, 200);
                1: age_if.last_accessed = curr_time + $urandom_range(1, 20);
                default: age_if.last_accessed = $urandom;
            endcase
            cycle();
        end
        age_if.check_age = 1'b0;
        cycle();

        curr_time = 32'd100000; max_age = 32'd100;
        for (int i = 0; i < DEPTH; i++)
            img[i] = mk((i % 5) != 0, (i % 5) != 0 ? curr_time - 32'd10 : 32'd0, 2'(i), {40'hA5_0000_0000, 8'(i)});
        img[8'h03] = mk(1'b1, curr_time - 32'd500, 2'd1, 48'h0000_1111_0003);
        img[8'hFF] = mk(1'b1, curr_time - 32'd101, 2'd2, 48'hCAFE_0000_00FF);
        load_img();
        run_sweep(1'b0, 1'b1, "sweep_dir");

        for (int i = 0; i < DEPTH; i++) img[i] = mk(1'b1, curr_time - 32'd20, 2'(i), {40'hB0_0000_0000, 8'(i)});
        img[8'h10] = mk(1'b1, curr_time - 32'd300, 2'd3, 48'h1234_5678_0010);
        load_img();
        command = 2'b10;
        cycle();
        command = 2'b00;
        wait_addr(8'h10);
        cycle();
        base = wr_log.size();
        age_if.add_check_active = 1'b1;
        chk_addr = 8'h20;
        for (int n = 0; n < 8; n++) begin
            age_if.check_age = (n == 3);
            age_if.last_accessed = curr_time - 32'd5;
            cycle();
            if (n == 3) chk("cont_req_answered", age_if.age_confirmed, 1'b1);
        end
        age_if.check_age = 1'b0;
        chk("cont_no_write", wr_log.size(), base);
        age_if.add_check_active = 1'b0;
        run_sweep(1'b0, 1'b0, "sweep_cont");

        img[8'h03] = mk(1'b1, curr_time - 32'd900, 2'd1, 48'hDEAD_0000_0003);
        img[8'h90] = mk(1'b1, curr_time - 32'd900, 2'd2, 48'hBEEF_0000_0090);
        img[8'h10] = mk(1'b1, curr_time - 32'd20, 2'd0, 48'h0);
        load_img();
        command = 2'b10;
        cycle();
        command = 2'b00;
        wait_addr(8'h80);
        base = wr_log.size();
        n_p_reset = 1'b0;
        cycle();
        chk("rst_mid_active", age_sweep_active, 1'b0);
        chk("rst_mid_wr", age_if.mem_write_age, 1'b0);
        chk("rst_mid_addr", age_if.mem_addr_age, 8'h00);
        chk("rst_mid_inval", inval_count, 9'h0);
        chk("rst_mid_lst_addr", lst_inv_addr_cmd, 48'h0);
        n_p_reset = 1'b1;
        for (int n = 0; n < 20; n++) cycle();
        chk("rst_mid_no_writes", wr_log.size(), base);
        run_sweep(1'b0, 1'b1, "sweep_restart");

        curr_time = 32'd1_000_000; max_age = 32'd150;
        for (int i = 0; i < DEPTH; i++)
            img[i] = mk($urandom_range(0, 3) != 0,
                        ($urandom_range(0, 5) == 0) ? curr_time + $urandom_range(1, 50) : curr_time - $urandom_range(0, 300),
                        2'($urandom), {16'($urandom), 32'($urandom)});
        load_img();
        run_sweep(1'b1, 1'b1, "sweep_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
